// File: rtl/liteic_pkg.sv
// Shared liteic return-path definitions: response codes and
// index-to-one-hot steering helper.
package liteic_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Out-of-range indices yield zero so a bad ID steers nowhere.
    function automatic logic [31:0] onehot_from_idx(input logic [31:0] idx);
        onehot_from_idx = (idx < 32'd32) ? (32'd1 << idx) : 32'd0;
    endfunction

endpackage

// File: rtl/liteic_resp_router_if.sv
// Read-response channels around one liteic return-path router:
// slave R channel in, per-master R channel out.
interface liteic_resp_router_if #(
    parameter int MST_NUM = 4,
    parameter int DATA_W  = 32
);
    logic               s_rvalid;
    logic [DATA_W-1:0]  s_rdata;
    logic [1:0]         s_rresp;
    logic               s_rready;
    logic [MST_NUM-1:0] m_rvalid;
    logic [DATA_W-1:0]  m_rdata;
    logic [1:0]         m_rresp;
    logic [MST_NUM-1:0] m_rready;

    modport slave (
        input  s_rvalid, s_rdata, s_rresp, m_rready,
        output s_rready, m_rvalid, m_rdata, m_rresp
    );

    modport master (
        output s_rvalid, s_rdata, s_rresp, m_rready,
        input  s_rready, m_rvalid, m_rdata, m_rresp
    );
endinterface

// File: rtl/liteic_id_fifo.sv
// Small ID FIFO with count-based full/empty; shared by the
// read- and write-response routers.
module liteic_id_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       data_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok, pop_ok;

    always_comb begin
        full_o   = (count_q == CNT_W'(DEPTH));
        empty_o  = (count_q == '0);
        push_ok  = push_i && !full_o;
        pop_ok   = pop_i && !empty_o;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        data_o  = mem_q[rd_ptr_q];
        count_o = count_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload needs no reset; it is only read behind a nonzero count.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/liteic_resp_router.sv
// Per-slave read-response router: queues granted master IDs in issue
// order and steers each slave response to one master via an output reg.
module liteic_resp_router
    import liteic_pkg::*;
#(
    parameter int MST_NUM = 4,
    parameter int ID_W    = $clog2(MST_NUM),
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   req_valid_i,
    input  logic [ID_W-1:0]        req_id_i,
    output logic                   req_ready_o,
    liteic_resp_router_if.slave    rif,
    output logic [$clog2(DEPTH):0] outstanding_o
);
    logic               fifo_full, fifo_empty;
    logic [ID_W-1:0]    head_id;
    logic [MST_NUM-1:0] sel_oh;
    logic               sel_rdy, s_rready, accept;

    logic               out_valid_q, out_valid_d;
    logic [ID_W-1:0]    out_id_q, out_id_d;
    logic [DATA_W-1:0]  out_data_q, out_data_d;
    logic [1:0]         out_resp_q, out_resp_d;

    liteic_id_fifo #(
        .WIDTH (ID_W),
        .DEPTH (DEPTH)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (req_valid_i),
        .data_i  (req_id_i),
        .pop_i   (accept),
        .data_o  (head_id),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (outstanding_o)
    );

    // An ID with no matching master acts as always-ready so it drains.
    always_comb begin
        sel_oh   = MST_NUM'(onehot_from_idx(32'(out_id_q)));
        sel_rdy  = (sel_oh == '0) || (|(sel_oh & rif.m_rready));
        s_rready = !fifo_empty && (!out_valid_q || sel_rdy);
        accept   = rif.s_rvalid && s_rready;
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_id_d    = out_id_q;
        out_data_d  = out_data_q;
        out_resp_d  = out_resp_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_id_d    = head_id;
            out_data_d  = rif.s_rdata;
            out_resp_d  = rif.s_rresp;
        end else if (out_valid_q && sel_rdy) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_q <= 1'b0;
            out_id_q    <= '0;
            out_data_q  <= '0;
            out_resp_q  <= RESP_OKAY;
        end else begin
            out_valid_q <= out_valid_d;
            out_id_q    <= out_id_d;
            out_data_q  <= out_data_d;
            out_resp_q  <= out_resp_d;
        end
    end

    always_comb begin
        req_ready_o  = !fifo_full;
        rif.s_rready = s_rready;
        rif.m_rvalid = out_valid_q ? sel_oh : '0;
        rif.m_rdata  = out_data_q;
        rif.m_rresp  = out_resp_q;
    end

endmodule

// File: tb/tb_liteic_resp_router.sv
// Bench for liteic_resp_router: vector table, directed corner
// sequences and random traffic against a queue-based reference.
module tb_liteic_resp_router;
    import liteic_pkg::*;

    localparam int MST = 4;
    localparam int DW  = 32;
    localparam int DEP = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic [1:0] req_id;
    logic       req_ready;
    logic [2:0] outstanding;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    liteic_resp_router_if #(.MST_NUM(MST), .DATA_W(DW)) rif ();

    liteic_resp_router #(
        .MST_NUM (MST),
        .DATA_W  (DW),
        .DEPTH   (DEP)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .req_valid_i   (req_valid),
        .req_id_i      (req_id),
        .req_ready_o   (req_ready),
        .rif           (rif.slave),
        .outstanding_o (outstanding)
    );

    // reference: queue of pending IDs plus the one held response
    int          mq[$];
    bit          mv;
    int          mid;
    logic [31:0] md;
    logic [1:0]  mr;

    typedef struct {
        bit          rv;
        logic [1:0]  id;
        bit          sv;
        logic [31:0] sd;
        logic [1:0]  sr;
        logic [3:0]  rdy;
        logic [3:0]  e_mrv;
        logic [31:0] e_d;
        logic [1:0]  e_r;
        bit          e_srr;
        bit          e_reqr;
        logic [2:0]  e_out;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h @%0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic bit m_srr();
        return (mq.size() != 0) && (!mv || rif.m_rready[mid]);
    endfunction

    task automatic sample(input bit use_model);
        @(negedge clk);
        if (use_model) begin
            chk("req_ready", req_ready, mq.size() < DEP);
            chk("s_rready", rif.s_rready, m_srr());
            chk("m_rvalid", rif.m_rvalid, mv ? (4'b1 << mid) : 4'b0);
            chk("m_rdata", rif.m_rdata, md);
            chk("m_rresp", rif.m_rresp, mr);
            chk("outstanding", outstanding, mq.size());
            chk("onehot", $countones(rif.m_rvalid) <= 1, 1);
        end
    endtask

    task automatic advance();
        bit acc, psh;
        if (rst) begin
            mq.delete();
            mv = 0; mid = 0; md = '0; mr = '0;
        end else begin
            acc = rif.s_rvalid && m_srr();
            psh = req_valid && (mq.size() < DEP);
            if (acc) begin
                mid = mq.pop_front();
                mv  = 1;
                md  = rif.s_rdata;
                mr  = rif.s_rresp;
            end else if (mv && rif.m_rready[mid]) begin
                mv = 0;
            end
            if (psh) mq.push_back(int'(req_id));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit rv, input logic [1:0] id,
                         input bit sv, input logic [31:0] sd,
                         input logic [1:0] sr, input logic [3:0] rdy);
        req_valid    = rv;
        req_id       = id;
        rif.s_rvalid = sv;
        rif.s_rdata  = sd;
        rif.s_rresp  = sr;
        rif.m_rready = rdy;
    endtask

    task automatic add(input bit rv, input logic [1:0] id, input bit sv,
                       input logic [31:0] sd, input logic [1:0] sr,
                       input logic [3:0] e_mrv, input logic [31:0] e_d,
                       input logic [1:0] e_r, input bit e_srr,
                       input bit e_reqr, input logic [2:0] e_out);
        vec_t v;
        v.rv = rv; v.id = id; v.sv = sv; v.sd = sd; v.sr = sr;
        v.rdy = 4'hF; v.e_mrv = e_mrv; v.e_d = e_d; v.e_r = e_r;
        v.e_srr = e_srr; v.e_reqr = e_reqr; v.e_out = e_out;
        vecs.push_back(v);
    endtask

    task automatic drain();
        int n;
        drive(0, 0, 0, 0, 0, 4'hF);
        n = 0;
        while ((mq.size() != 0 || mv) && n < 20) begin
            if (mq.size() != 0) rif.s_rvalid = 1;
            sample(1);
            advance();
            rif.s_rvalid = 0;
            n++;
        end
        chk("drain_timeout", n < 20, 1);
    endtask

    localparam logic [31:0] DA = 32'hA0A0_0001;
    localparam logic [31:0] DB = 32'hB0B0_0002;
    localparam logic [31:0] DC = 32'hC0C0_0003;
    localparam logic [31:0] DD = 32'hD0D0_0004;
    localparam logic [31:0] DE = 32'hE0E0_0005;
    localparam logic [31:0] DF = 32'hF0F0_0006;
    localparam logic [31:0] DG = 32'h1234_0007;
    localparam logic [31:0] DH = 32'h5678_0008;

    initial begin
        rst = 1;
        drive(0, 0, 0, 0, 0, 4'h0);
        sample(0);
        advance();
        rst = 0;
        sample(0);
        chk("rst_m_rvalid", rif.m_rvalid, 4'b0);
        chk("rst_m_rdata", rif.m_rdata, 32'h0);
        chk("rst_m_rresp", rif.m_rresp, 2'b0);
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_s_rready", rif.s_rready, 1'b0);
        chk("rst_outstanding", outstanding, 3'd0);
        advance();

        // in-order routing IDs 2,0,3, then fill and overflow attempt
        add(1, 2, 0, 0,  0,           4'b0000, 0,  0,           0, 1, 0);
        add(1, 0, 0, 0,  0,           4'b0000, 0,  0,           1, 1, 1);
        add(1, 3, 0, 0,  0,           4'b0000, 0,  0,           1, 1, 2);
        add(0, 0, 1, DA, RESP_OKAY,   4'b0000, 0,  0,           1, 1, 3);
        add(0, 0, 1, DB, RESP_SLVERR, 4'b0100, DA, RESP_OKAY,   1, 1, 2);
        add(0, 0, 1, DC, RESP_OKAY,   4'b0001, DB, RESP_SLVERR, 1, 1, 1);
        add(0, 0, 0, 0,  0,           4'b1000, DC, RESP_OKAY,   0, 1, 0);
        add(0, 0, 0, 0,  0,           4'b0000, DC, RESP_OKAY,   0, 1, 0);
        add(1, 1, 0, 0,  0,           4'b0000, DC, RESP_OKAY,   0, 1, 0);
        add(1, 2, 0, 0,  0,           4'b0000, DC, RESP_OKAY,   1, 1, 1);
        add(1, 3, 0, 0,  0,           4'b0000, DC, RESP_OKAY,   1, 1, 2);
        add(1, 0, 0, 0,  0,           4'b0000, DC, RESP_OKAY,   1, 1, 3);
        add(1, 1, 1, DD, RESP_OKAY,   4'b0000, DC, RESP_OKAY,   1, 0, 4);
        add(0, 0, 0, 0,  0,           4'b0010, DD, RESP_OKAY,   1, 1, 3);
        add(0, 0, 1, DE, RESP_OKAY,   4'b0000, DD, RESP_OKAY,   1, 1, 3);
        add(0, 0, 1, DF, RESP_OKAY,   4'b0100, DE, RESP_OKAY,   1, 1, 2);
        add(0, 0, 1, DG, RESP_OKAY,   4'b1000, DF, RESP_OKAY,   1, 1, 1);
        add(0, 0, 0, 0,  0,           4'b0001, DG, RESP_OKAY,   0, 1, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rv, vecs[i].id, vecs[i].sv, vecs[i].sd,
                  vecs[i].sr, vecs[i].rdy);
            sample(0);
            chk($sformatf("v%0d_m_rvalid", i), rif.m_rvalid, vecs[i].e_mrv);
            chk($sformatf("v%0d_m_rdata", i), rif.m_rdata, vecs[i].e_d);
            chk($sformatf("v%0d_m_rresp", i), rif.m_rresp, vecs[i].e_r);
            chk($sformatf("v%0d_s_rready", i), rif.s_rready, vecs[i].e_srr);
            chk($sformatf("v%0d_req_ready", i), req_ready, vecs[i].e_reqr);
            chk($sformatf("v%0d_outstanding", i), outstanding, vecs[i].e_out);
            advance();
        end

        // master 1 stalls while slave keeps streaming
        drive(1, 1, 0, 0, 0, 4'hF);
        sample(1); advance();
        sample(1); advance();
        drive(0, 0, 1, DH, RESP_OKAY, 4'b1101);
        sample(1); advance();
        rif.s_rdata = DA;
        for (int i = 0; i < 5; i++) begin
            sample(1);
            chk("stall_m_rvalid", rif.m_rvalid, 4'b0010);
            chk("stall_m_rdata", rif.m_rdata, DH);
            chk("stall_s_rready", rif.s_rready, 1'b0);
            advance();
        end
        drain();

        // stray response with empty queue, then late push of ID 3
        drive(0, 0, 1, DB, RESP_OKAY, 4'hF);
        sample(1);
        chk("stray_s_rready", rif.s_rready, 1'b0);
        chk("stray_m_rvalid", rif.m_rvalid, 4'b0);
        advance();
        req_valid = 1; req_id = 3;
        sample(1);
        chk("push_edge_s_rready", rif.s_rready, 1'b0);
        advance();
        req_valid = 0;
        sample(1);
        chk("after_push_s_rready", rif.s_rready, 1'b1);
        advance();
        rif.s_rvalid = 0;
        sample(1);
        chk("late_m_rvalid", rif.m_rvalid, 4'b1000);
        chk("late_m_rdata", rif.m_rdata, DB);
        advance();

        // reset while a response is held and an ID is queued
        drive(1, 0, 0, 0, 0, 4'h0);
        sample(1); advance();
        req_id = 1;
        sample(1); advance();
        drive(0, 0, 1, DC, RESP_SLVERR, 4'h0);
        sample(1); advance();
        rif.s_rvalid = 0;
        sample(1);
        chk("held_m_rvalid", rif.m_rvalid, 4'b0001);
        chk("held_outstanding", outstanding, 3'd1);
        advance();
        rst = 1;
        sample(1); advance();
        rst = 0;
        sample(1);
        chk("mid_rst_m_rvalid", rif.m_rvalid, 4'b0);
        chk("mid_rst_m_rdata", rif.m_rdata, 32'h0);
        chk("mid_rst_m_rresp", rif.m_rresp, 2'b0);
        chk("mid_rst_outstanding", outstanding, 3'd0);
        chk("mid_rst_req_ready", req_ready, 1'b1);
        chk("mid_rst_s_rready", rif.s_rready, 1'b0);
        advance();

        // random traffic
        for (int c = 0; c < 10000; c++) begin
            rst          = ($urandom_range(0, 999) == 0);
            req_valid    = $urandom_range(0, 1) == 1;
            req_id       = 2'($urandom_range(0, 3));
            rif.s_rvalid = $urandom_range(0, 3) != 0;
            rif.s_rdata  = $urandom;
            rif.s_rresp  = 2'($urandom_range(0, 3));
            rif.m_rready = ($urandom_range(0, 2) == 0) ?
                           4'($urandom_range(0, 15)) : 4'hF;
            sample(1);
            advance();
        end
        rst = 0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/liteic_resp_router.md
# liteic_resp_router

Return-path router for one slave port of the liteic AXI-lite interconnect: it decodes stored binary master IDs back into one-hot response steering. The request-side arbiter produces a binary grant index for each accepted read address. This block queues those indices in issue order, and as each slave read response arrives, steers it to exactly one master through a registered output stage. One instance sits per slave port, between the slave R channel and the master-side R channel fan-out.

## Interface
- MST_NUM, 4, number of masters (≥2)
- ID_W, $clog2(MST_NUM), width of binary master index
- DATA_W, 32, read data width
- DEPTH, 4, max outstanding reads per slave (power of two, ≥2)
- clk_i  in  1  clock; everything on rising edge
- rst_i  in  1  reset, synchronous, active-high
- req_valid_i  in  1  arbiter issued a read address to this slave
- req_id_i  in  ID_W  binary index of the granted master
- req_ready_o  out  1  ID queue can accept (not full)
- s_rvalid_i  in  1  slave response valid
- s_rdata_i  in  DATA_W  slave response data
- s_rresp_i  in  2  slave response code
- s_rready_o  out  1  response accepted this cycle when high with s_rvalid_i
- m_rvalid_o  out  MST_NUM  one-hot response valid per master
- m_rdata_o  out  DATA_W  response data, broadcast to all masters
- m_rresp_o  out  2  response code, broadcast
- m_rready_i  in  MST_NUM  per-master ready
- outstanding_o  out  $clog2(DEPTH)+1  entries currently queued

## Operation
- ID queue: FIFO of DEPTH entries of ID_W bits.
  - Push when req_valid_i && req_ready_o. req_ready_o = !full.
  - Pop when a slave response is accepted.
  - Requests with req_valid_i high while full are not recorded; the arbiter must hold off.
- s_rready_o = !empty && (!out_valid || m_rready_i[out_id]).
  - No response is accepted while the queue is empty. A stray s_rvalid_i is stalled, never dropped.
- On accept, load the output register: out_valid=1, out_id=head ID, out_data/out_resp=slave values. The head ID is popped in the same cycle.
- Output drive:
  - m_rvalid_o = out_valid ? (1 << out_id) : 0, so never more than one bit is set.
  - m_rdata_o/m_rresp_o are driven from the register regardless of valid.
- Output register clears when m_rready_i[out_id] is high and no new accept happens that cycle. If a new accept happens in that cycle, the register reloads instead (back-to-back, full throughput).
- out_valid holds, and data stays stable, while the selected master's ready is low. Ready bits of non-selected masters are ignored.
- Simultaneous push and pop:
  - Not full: both occur and the count is unchanged.
  - Full: only the pop occurs. req_ready_o is computed from the registered full flag, with no same-cycle pass-through.
  - Empty: the push occurs. The new entry is routable from the next cycle.
- Pointers wrap modulo DEPTH; full/empty are derived from a count register of $clog2(DEPTH)+1 bits. outstanding_o = count.
- Any req_id_i ≥ MST_NUM is a protocol error. Its response is routed to no master (m_rvalid_o=0), and the register clears on the next cycle.

## Timing
- Reset values: count=0, pointers=0, out_valid=0, m_rvalid_o=0, m_rdata_o=0, m_rresp_o=0.
  - Derived outputs then read req_ready_o=1, s_rready_o=0, outstanding_o=0.
- Reset asserted mid-operation discards all queued IDs and any held response in the same edge.
- Latency:
  - Slave accept at edge N → m_rvalid_o visible after edge N.
  - Push at edge N → s_rready_o may rise after edge N.
- Sustained throughput is 1 response/cycle when the selected master keeps ready high.

## Structure
- liteic_pkg holds the resp code constants (OKAY=2'b00, SLVERR=2'b10) and an onehot_from_idx function shared with other return-path blocks.
- Natural sub-module: liteic_id_fifo (parameters WIDTH and DEPTH, push/pop/full/empty/count). It is reusable for the write-response router.
- Decode and output register stay in the top.

## Test plan
- Push IDs 2,0,3; slave returns data A,B,C with all ready high → m_rvalid_o = 0100, 0001, 1000 on consecutive cycles with data A,B,C; outstanding_o goes 3→0.
- Fill 4 pushes → req_ready_o=0. Fifth push with a simultaneous response accept → push not recorded, count=3.
- Queue ID 1, hold m_rready_i[1]=0 for 5 cycles with s_rvalid_i streaming → m_rvalid_o=0010 and data held stable; s_rready_o=0 after the first accept.
- s_rvalid_i=1 with empty queue → s_rready_o=0 and m_rvalid_o=0. A push of ID 3 at edge N → accept at edge N+1, m_rvalid_o=1000 after N+1.
- Two queued, first response held, rst_i pulsed one cycle → all outputs at reset values, outstanding_o=0, req_ready_o=1.
- Random push/response/ready traffic for 10k cycles against a scoreboard → in-order routing and one-hot m_rvalid_o hold on every cycle.
